seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receive end of the board's multiplexed 7-segment display interface.
- Samples the scanned digit-enable and segment lines driven by cpu_top, decodes each digit back to a hex nibble, and reassembles the 32-bit displayed value.
- Emits a one-cycle strobe per complete frame.
- Used in board-level benches, and as an on-board loopback checker, to compare the displayed value against expected CPU results without waveform inspection.

Parameters:
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is captured (2..255).
- FRAME_TIMEOUT, 4096: cycles without any capture before a partial frame is discarded (16..65535).
- EN_ACTIVE_LOW, 1: 1 means a digit is selected when its led_en bit is 0.
- SEG_ACTIVE_LOW, 1: 1 means a segment or dp is lit when its led_c bit is 0.

Ports:
- clk, in, 1: system clock.
- rst_i, in, 1: asynchronous active-high reset.
- led_en_i, in, 8: digit enables; bit i selects digit i; digit 7 is the most significant nibble.
- led_c_i, in, 8: {ca,cb,cc,cd,ce,cf,cg,dp}; bit 7 = ca, bit 0 = dp.
- value_o, out, 32: last complete frame; digit i occupies bits [4i+3:4i].
- dp_o, out, 8: decimal-point state per digit, last frame.
- bad_o, out, 8: per digit, 1 when the captured pattern was not a legal hex glyph.
- valid_o, out, 1: one-cycle pulse when value_o, dp_o and bad_o update.
- changed_o, out, 1: qualified by valid_o; 1 when the new value_o differs from the previous frame's value_o.
- timeout_o, out, 1: one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset: clears all outputs to 0, the seen mask, the counters and the digit registers; FSM goes to IDLE. The reset is asynchronous and takes effect immediately, including mid-frame.
- Input path:
  - Both buses pass through a 2-flop synchronizer.
  - Polarity is then normalized to active-high: en, seg[6:0] = {a..g}, dp.
- Selection legality:
  - en must be exactly one-hot. All-zero (blank) or multi-hot is illegal.
  - Illegal selection forces the FSM to IDLE and the stability count to 0.
- FSM states:
  - IDLE: when en is legal, load the sample, count=1, go to DWELL.
  - DWELL: if the sample equals the stored sample, count++; otherwise reload the sample, count=1, stay in DWELL. When count reaches SETTLE_CYCLES, capture and go to HELD.
  - HELD: the digit is already captured for this dwell. Stay while the sample is unchanged. A changed legal sample goes to DWELL with count=1; an illegal sample goes to IDLE.
  - A digit is therefore captured at most once per dwell.
- Capture actions:
  - digit_r[idx] <= decoded nibble; dp_r[idx] <= dp; bad_r[idx] <= illegal glyph; seen[idx] <= 1.
  - Idle counter resets to 0.
- Decode table, {a..g} active-high hex → nibble:
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9.
  - 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F.
  - Any other pattern, including all-off, → nibble 0 with bad set.
- Frame completion:
  - On the cycle after seen becomes 8'hFF: value_o, dp_o and bad_o load from the digit registers; valid_o=1; changed_o=(new value_o != old value_o); seen clears.
  - A capture landing in the same cycle as the seen clear is kept: its seen bit stays set.
  - The first frame after reset compares against 0.
- Re-capture: a digit captured twice before the frame completes overwrites its earlier value; seen is unaffected.
- Timeout:
  - The idle counter increments every cycle without a capture and saturates.
  - When it reaches FRAME_TIMEOUT with seen != 0: seen clears, timeout_o pulses for one cycle, and the counter restarts.
  - A timeout with seen == 0 produces no pulse.
- Latency: from pin change to capture = 2 (sync) + SETTLE_CYCLES cycles; valid_o follows the final capture by 1 cycle.
- Between frames, value_o, dp_o and bad_o hold their values.

Test Plan:
1. Scan digits 0..7 showing 0x1234ABCD, 8-cycle dwell, active-low drive, dp all off → one valid_o pulse; value_o=0x1234ABCD, dp_o=0x00, bad_o=0x00, changed_o=1.
2. Same scan with 3-cycle dwell (SETTLE_CYCLES=4) → no capture; valid_o never asserts; after 4096 cycles a timeout occurs with seen=0, so no timeout_o pulse.
3. Digit 3 segments all off, digit 5 pattern 0x01 with dp lit, rest 0x0 → value_o=0x00000000, bad_o=0x28, dp_o=0x20.
4. Repeat frame 1 twice, then change digit 0 to 0xE → second valid_o with changed_o=0; third valid_o with changed_o=1 and value_o=0x1234ABCE.
5. Capture digits 0..4, then hold en=8'hFF (blank) → timeout_o pulses exactly FRAME_TIMEOUT cycles after the last capture; a following full frame of 0x00000042 yields valid_o with value_o=0x00000042.
6. Assert rst_i for 1 cycle after digit 6 of a frame → all outputs 0 immediately; the remaining digit 7 alone produces no valid_o; the next full frame produces valid_o.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment display bus.
// Samples the scanned digit enables and segment lines, waits for each digit
// to dwell stably, decodes the glyph back to a hex nibble and reassembles the
// displayed 32-bit value, emitting a one-cycle strobe per complete frame.
//
// state | meaning
// IDLE  | no legal one-hot digit selection present
// DWELL | legal selection present, counting identical samples
// HELD  | current dwell already captured, waiting for the sample to change
module seg7_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int FRAME_TIMEOUT  = 4096,
    parameter int EN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  led_en_i,
    input  logic [7:0]  led_c_i,
    output logic [31:0] value_o,
    output logic [7:0]  dp_o,
    output logic [7:0]  bad_o,
    output logic        valid_o,
    output logic        changed_o,
    output logic        timeout_o
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_DWELL = 2'd1;
    localparam logic [1:0]  ST_HELD  = 2'd2;

    localparam logic [7:0]  SETTLE_L  = 8'(SETTLE_CYCLES);
    localparam logic [15:0] TIMEOUT_L = 16'(FRAME_TIMEOUT);

    // synchronizer flops
    logic [7:0]  en_s1_q, en_s2_q, c_s1_q, c_s2_q;
    logic [7:0]  en_s1_d, en_s2_d, c_s1_d, c_s2_d;

    // FSM and dwell tracking
    logic [1:0]  state_q, state_d;
    logic [15:0] samp_q, samp_d;
    logic [7:0]  cnt_q, cnt_d;

    // digit registers, frame bookkeeping and outputs
    logic [31:0] digit_q, digit_d;
    logic [7:0]  dpr_q, dpr_d;
    logic [7:0]  badr_q, badr_d;
    logic [7:0]  seen_q, seen_d;
    logic [15:0] idle_q, idle_d;
    logic [31:0] value_q, value_d;
    logic [7:0]  dp_q, dp_d;
    logic [7:0]  bad_q, bad_d;
    logic        valid_q, valid_d;
    logic        changed_q, changed_d;
    logic        timeout_q, timeout_d;

    // normalized sample
    logic [7:0]  en_n;
    logic [7:0]  c_n;
    logic [6:0]  seg;
    logic        dp;
    logic        legal;
    logic [2:0]  idx;
    logic [15:0] sample;
    logic [3:0]  nib;
    logic        glyph_bad;
    logic        capture;
    logic        complete;

    // Two-flop synchronizer inputs.
    always_comb begin
        en_s1_d = led_en_i;
        en_s2_d = en_s1_q;
        c_s1_d  = led_c_i;
        c_s2_d  = c_s1_q;
    end

    // Normalize polarity, check one-hot selection, find digit index.
    always_comb begin
        en_n   = (EN_ACTIVE_LOW != 0) ? ~en_s2_q : en_s2_q;
        c_n    = (SEG_ACTIVE_LOW != 0) ? ~c_s2_q : c_s2_q;
        seg    = c_n[7:1];
        dp     = c_n[0];
        legal  = (en_n != 8'd0) && ((en_n & (en_n - 8'd1)) == 8'd0);
        sample = {en_n, c_n};
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (en_n[i]) begin
                idx = 3'(i);
            end
        end
    end

    // Glyph decode; unknown patterns (including blank) decode to 0 and flag bad.
    always_comb begin
        nib       = 4'h0;
        glyph_bad = 1'b0;
        case (seg)
            7'h7E:   nib = 4'h0;
            7'h30:   nib = 4'h1;
            7'h6D:   nib = 4'h2;
            7'h79:   nib = 4'h3;
            7'h33:   nib = 4'h4;
            7'h5B:   nib = 4'h5;
            7'h5F:   nib = 4'h6;
            7'h70:   nib = 4'h7;
            7'h7F:   nib = 4'h8;
            7'h7B:   nib = 4'h9;
            7'h77:   nib = 4'hA;
            7'h1F:   nib = 4'hB;
            7'h4E:   nib = 4'hC;
            7'h3D:   nib = 4'hD;
            7'h4F:   nib = 4'hE;
            7'h47:   nib = 4'hF;
            default: glyph_bad = 1'b1;
        endcase
    end

    // Dwell FSM: a digit is captured once per stable dwell.
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (legal) begin
                    samp_d  = sample;
                    cnt_d   = 8'd1;
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (!legal) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (sample == samp_q) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == SETTLE_L) begin
                        capture = 1'b1;
                        state_d = ST_HELD;
                    end
                end else begin
                    samp_d = sample;
                    cnt_d  = 8'd1;
                end
            end
            ST_HELD: begin
                if (!legal) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (sample != samp_q) begin
                    samp_d  = sample;
                    cnt_d   = 8'd1;
                    state_d = ST_DWELL;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Digit capture, frame completion and partial-frame timeout.
    always_comb begin
        digit_d   = digit_q;
        dpr_d     = dpr_q;
        badr_d    = badr_q;
        seen_d    = seen_q;
        idle_d    = idle_q;
        value_d   = value_q;
        dp_d      = dp_q;
        bad_d     = bad_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        timeout_d = 1'b0;
        complete  = (seen_q == 8'hFF);

        if (complete) begin
            value_d   = digit_q;
            dp_d      = dpr_q;
            bad_d     = badr_q;
            valid_d   = 1'b1;
            changed_d = (digit_q != value_q);
            seen_d    = 8'd0;
        end

        if (capture) begin
            idle_d = 16'd0;
        end else if (idle_q != TIMEOUT_L) begin
            idle_d = idle_q + 16'd1;
            // counter only restarts when there is a partial frame to drop
            if ((idle_q + 16'd1 == TIMEOUT_L) && (seen_q != 8'd0)) begin
                idle_d    = 16'd0;
                timeout_d = 1'b1;
                seen_d    = 8'd0;
            end
        end

        // applied after the clears so a coincident capture keeps its seen bit
        if (capture) begin
            digit_d[{idx, 2'b00} +: 4] = nib;
            dpr_d[idx]                 = dp;
            badr_d[idx]                = glyph_bad;
            seen_d[idx]                = 1'b1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            en_s1_q   <= 8'd0;
            en_s2_q   <= 8'd0;
            c_s1_q    <= 8'd0;
            c_s2_q    <= 8'd0;
            state_q   <= ST_IDLE;
            samp_q    <= 16'd0;
            cnt_q     <= 8'd0;
            digit_q   <= 32'd0;
            dpr_q     <= 8'd0;
            badr_q    <= 8'd0;
            seen_q    <= 8'd0;
            idle_q    <= 16'd0;
            value_q   <= 32'd0;
            dp_q      <= 8'd0;
            bad_q     <= 8'd0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            en_s1_q   <= en_s1_d;
            en_s2_q   <= en_s2_d;
            c_s1_q    <= c_s1_d;
            c_s2_q    <= c_s2_d;
            state_q   <= state_d;
            samp_q    <= samp_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            dpr_q     <= dpr_d;
            badr_q    <= badr_d;
            seen_q    <= seen_d;
            idle_q    <= idle_d;
            value_q   <= value_d;
            dp_q      <= dp_d;
            bad_q     <= bad_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            timeout_q <= timeout_d;
        end
    end

    assign value_o   = value_q;
    assign dp_o      = dp_q;
    assign bad_o     = bad_q;
    assign valid_o   = valid_q;
    assign changed_o = changed_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: stimulus pushes predicted frame and
// timeout events (with their cycle) into a queue; a monitor pops on each pulse.
module tb_seg7_scan_capture;

    localparam int S = 4;
    localparam int T = 4096;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  led_en_i, led_c_i;
    logic [31:0] value_o;
    logic [7:0]  dp_o, bad_o;
    logic        valid_o, changed_o, timeout_o;

    seg7_scan_capture #(
        .SETTLE_CYCLES(S), .FRAME_TIMEOUT(T), .EN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_i(rst_i), .led_en_i(led_en_i), .led_c_i(led_c_i),
        .value_o(value_o), .dp_o(dp_o), .bad_o(bad_o), .valid_o(valid_o),
        .changed_o(changed_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          is_to;
        int          at;
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  bad;
        bit          changed;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  n_valid_seen = 0, n_to_seen = 0, n_valid_exp = 0, n_to_exp = 0;
    logic [31:0] shown_v = 32'd0;
    logic [7:0]  shown_dp = 8'd0, shown_bad = 8'd0;
    logic        obs_changed = 1'b0;

    // reference model state
    logic [3:0]  m_dig [8];
    logic        m_dp [8];
    logic        m_bad [8];
    logic [7:0]  m_seen;
    logic [31:0] m_prev;
    int          m_last_cap;

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) begin
            m_dig[i] = 4'h0; m_dp[i] = 1'b0; m_bad[i] = 1'b0;
        end
        m_seen     = 8'd0;
        m_prev     = 32'd0;
        m_last_cap = 0;
    endfunction

    // a partial frame is dropped if T edges pass after the last capture
    function automatic void m_timeout_upto(input int e);
        ev_t ev;
        if (m_seen != 8'd0 && m_last_cap + T <= e) begin
            ev.is_to = 1'b1; ev.at = m_last_cap + T;
            ev.value = 32'd0; ev.dp = 8'd0; ev.bad = 8'd0; ev.changed = 1'b0;
            exp_q.push_back(ev);
            n_to_exp++;
            m_seen = 8'd0;
        end
    endfunction

    function automatic void m_capture(input int e, input int idx, input logic [6:0] seg, input logic dp);
        ev_t ev;
        logic [31:0] v;
        m_timeout_upto(e - 1);
        m_dig[idx] = 4'h0;
        m_bad[idx] = 1'b1;
        for (int n = 0; n < 16; n++) begin
            if (glyph[n] == seg) begin
                m_dig[idx] = 4'(n);
                m_bad[idx] = 1'b0;
            end
        end
        m_dp[idx]   = dp;
        m_seen[idx] = 1'b1;
        m_last_cap  = e;
        if (m_seen == 8'hFF) begin
            v = 32'd0;
            ev.dp = 8'd0; ev.bad = 8'd0;
            for (int i = 0; i < 8; i++) begin
                v[4*i +: 4] = m_dig[i];
                ev.dp[i]    = m_dp[i];
                ev.bad[i]   = m_bad[i];
            end
            ev.is_to = 1'b0; ev.at = e + 1; ev.value = v; ev.changed = (v != m_prev);
            exp_q.push_back(ev);
            n_valid_exp++;
            m_prev = v;
            m_seen = 8'd0;
        end
    endfunction

    // idx: 0..7 digit, -1 blank, 8 multi-hot; called #1 after a rising edge
    task automatic dwell(input int idx, input logic [6:0] seg, input logic dp, input int len);
        int k;
        k = cyc;
        if (idx < 0)       led_en_i = 8'hFF;
        else if (idx == 8) led_en_i = 8'b1111_0011;
        else               led_en_i = ~(8'd1 << idx);
        led_c_i = ~{seg, dp};
        if (idx >= 0 && idx < 8 && len >= S) m_capture(k + S + 2, idx, seg, dp);
        m_timeout_upto(k + len);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [31:0] v, input logic [7:0] dps, input int len);
        for (int i = 0; i < 8; i++) dwell(i, glyph[v[4*i +: 4]], dps[i], len);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value"}, value_o, 32'd0);
        check({tag, "_dp"}, 32'(dp_o), 32'd0);
        check({tag, "_bad"}, 32'(bad_o), 32'd0);
        check({tag, "_pulses"}, {29'd0, valid_o, changed_o, timeout_o}, 32'd0);
    endtask

    task automatic on_event(input bit is_to);
        ev_t e;
        if (is_to) n_to_seen++; else n_valid_seen++;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse: got %s at cycle %0d expected none",
                     is_to ? "timeout_o" : "valid_o", cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(is_to), 32'(e.is_to));
            check("event_cycle", 32'(cyc), 32'(e.at));
            if (!is_to && !e.is_to) begin
                check("frame_value", value_o, e.value);
                check("frame_dp", 32'(dp_o), 32'(e.dp));
                check("frame_bad", 32'(bad_o), 32'(e.bad));
                check("frame_changed", 32'(changed_o), 32'(e.changed));
                shown_v = e.value; shown_dp = e.dp; shown_bad = e.bad;
                obs_changed = changed_o;
            end
        end
    endtask

    // monitor: compare every output pulse against the next predicted event
    always @(negedge clk) begin
        if (rst_i === 1'b0) begin
            if (timeout_o) on_event(1'b1);
            if (valid_o)   on_event(1'b0);
        end
    end

    task automatic check_shown(input string tag);
        check({tag, "_hold_value"}, value_o, shown_v);
        check({tag, "_hold_dp"}, 32'(dp_o), 32'(shown_dp));
        check({tag, "_hold_bad"}, 32'(bad_o), 32'(shown_bad));
    endtask

    initial begin
        int nv, nt;
        rst_i = 1'b1; led_en_i = 8'hFF; led_c_i = 8'hFF;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: basic frame
        frame(32'h1234ABCD, 8'h00, 8);
        dwell(-1, 7'h00, 1'b0, 10);
        check("t1_value", value_o, 32'h1234ABCD);
        check("t1_dp", 32'(dp_o), 32'h00);
        check("t1_bad", 32'(bad_o), 32'h00);
        check("t1_changed", 32'(obs_changed), 32'd1);
        check("t1_valid_count", 32'(n_valid_seen), 32'd1);

        // 2: dwell too short, no capture, no timeout pulse
        nv = n_valid_seen; nt = n_to_seen;
        frame(32'h1234ABCD, 8'h00, 3);
        dwell(-1, 7'h00, 1'b0, T + 20);
        check("t2_no_valid", 32'(n_valid_seen - nv), 32'd0);
        check("t2_no_timeout", 32'(n_to_seen - nt), 32'd0);
        check_shown("t2");

        // 3: blank glyph and illegal glyph with dp
        for (int i = 0; i < 8; i++) begin
            if (i == 3)      dwell(3, 7'h00, 1'b0, 8);
            else if (i == 5) dwell(5, 7'h01, 1'b1, 8);
            else             dwell(i, glyph[0], 1'b0, 8);
        end
        dwell(-1, 7'h00, 1'b0, 4);
        check("t3_value", value_o, 32'h00000000);
        check("t3_bad", 32'(bad_o), 32'h28);
        check("t3_dp", 32'(dp_o), 32'h20);

        // 4: repeated and changed frames
        nv = n_valid_seen;
        frame(32'h1234ABCD, 8'h00, 8);
        frame(32'h1234ABCD, 8'h00, 8);
        check("t4_repeat_changed", 32'(obs_changed), 32'd0);
        frame(32'h1234ABCE, 8'h00, 8);
        dwell(-1, 7'h00, 1'b0, 4);
        check("t4_value", value_o, 32'h1234ABCE);
        check("t4_changed", 32'(obs_changed), 32'd1);
        check("t4_valid_count", 32'(n_valid_seen - nv), 32'd3);

        // 5: partial frame times out, then a full frame
        for (int i = 0; i < 5; i++) dwell(i, glyph[(i == 0) ? 2 : ((i == 1) ? 4 : 0)], 1'b0, 8);
        nt = n_to_seen;
        dwell(-1, 7'h00, 1'b0, T + 20);
        check("t5_timeout_count", 32'(n_to_seen - nt), 32'd1);
        frame(32'h00000042, 8'h00, 8);
        dwell(-1, 7'h00, 1'b0, 4);
        check("t5_value", value_o, 32'h00000042);

        // 6: reset mid-frame
        for (int i = 0; i < 7; i++) dwell(i, glyph[i + 1], 1'b0, 8);
        led_en_i = 8'hFF; led_c_i = 8'hFF;
        rst_i = 1'b1;
        #1;
        check_zero("t6_reset");
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        m_reset();
        shown_v = 32'd0; shown_dp = 8'd0; shown_bad = 8'd0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        nv = n_valid_seen;
        dwell(7, glyph[8], 1'b0, 8);
        dwell(-1, 7'h00, 1'b0, 20);
        check("t6_lone_digit_no_valid", 32'(n_valid_seen - nv), 32'd0);
        frame(32'h87654321, 8'h00, 8);
        dwell(-1, 7'h00, 1'b0, 4);
        check("t6_valid_count", 32'(n_valid_seen - nv), 32'd1);
        check("t6_value", value_o, 32'h87654321);

        // random scans: out-of-order digits, short dwells, bad glyphs, multi-hot
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < 8; i++) begin
                int         idx;
                int         len;
                logic [6:0] seg;
                logic       dp;
                idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : i;
                len = int'($urandom_range(S - 1, S + 4));
                seg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
                dp  = 1'($urandom_range(0, 1));
                dwell(-1, 7'h00, 1'b0, 1);
                dwell(idx, seg, dp, len);
            end
        end
        dwell(-1, 7'h00, 1'b0, T + 10);
        repeat (5) @(posedge clk);
        #1;
        check_shown("final");
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_valid_count", 32'(n_valid_seen), 32'(n_valid_exp));
        check("final_timeout_count", 32'(n_to_seen), 32'(n_to_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
